// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: turns decoded load/store/call/ret controls into a single
// outstanding req/ack data-memory transaction. Optional ack timeout via MEM_ACK_TIMEOUT_EN.
module mem_stage_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              mem_to_reg,
    input  logic              reg_to_mem,
    input  logic              call,
    input  logic              rtrn,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata_out,
    output logic              rdata_valid,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    state_t              state_q, state_d;
    logic                req_d, we_d, rvld_d, err_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d, rdata_d;
    logic                rd_op, wr_op;
    logic                unused_ok;

    assign rd_op = mem_to_reg | rtrn;
    assign wr_op = reg_to_mem;
    // CALL is already a store through reg_to_mem; nothing else depends on it.
    assign unused_ok = call & (TIMEOUT >= 1);

`ifdef MEM_ACK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        req_d   = mem_req;
        we_d    = mem_we;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        rdata_d = rdata_out;
        rvld_d  = 1'b0;
        err_d   = 1'b0;
        stall   = 1'b0;
`ifdef MEM_ACK_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef MEM_ACK_TIMEOUT_EN
                cnt_d = '0;
`endif
                if (valid_in && (rd_op ^ wr_op)) begin
                    stall   = 1'b1;
                    req_d   = 1'b1;
                    we_d    = wr_op;
                    addr_d  = addr_in;
                    wdata_d = wdata_in;
                    state_d = REQ;
                end else if (valid_in && rd_op && wr_op) begin
                    stall   = 1'b1;
                    err_d   = 1'b1;
                    state_d = ERR;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (mem_ack) begin
                    req_d   = 1'b0;
                    rvld_d  = ~mem_we;
                    if (!mem_we) rdata_d = mem_rdata;
                    state_d = DONE;
                end
`ifdef MEM_ACK_TIMEOUT_EN
                // An ack arriving on the last allowed cycle still completes normally.
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rdata_out   <= '0;
            rdata_valid <= 1'b0;
            err         <= 1'b0;
`ifdef MEM_ACK_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req     <= req_d;
            mem_we      <= we_d;
            mem_addr    <= addr_d;
            mem_wdata   <= wdata_d;
            rdata_out   <= rdata_d;
            rdata_valid <= rvld_d;
            err         <= err_d;
`ifdef MEM_ACK_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: transaction-level model compared every cycle,
// plus directed literal checks. Honours MEM_ACK_TIMEOUT_EN when defined for the build.
module tb_mem_stage_ctrl;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 15;
`ifdef MEM_ACK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0, valid_in = 1'b0, mem_to_reg = 1'b0, reg_to_mem = 1'b0;
    logic call = 1'b0, rtrn = 1'b0, mem_ack = 1'b0;
    logic [ADDR_W-1:0] addr_in = '0, mem_addr;
    logic [DATA_W-1:0] wdata_in = '0, mem_wdata, mem_rdata = '0, rdata_out;
    logic mem_req, mem_we, stall, rdata_valid, err;

    mem_stage_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .mem_to_reg(mem_to_reg),
        .reg_to_mem(reg_to_mem), .call(call), .rtrn(rtrn), .addr_in(addr_in),
        .wdata_in(wdata_in), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
        .rdata_out(rdata_out), .rdata_valid(rdata_valid), .err(err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: acks after ack_delay cycles of mem_req when enabled.
    logic              ack_en    = 1'b1;
    int                ack_delay = 0;
    logic [DATA_W-1:0] rd_val    = '0;
    int                req_age   = 0;
    always @(posedge clk) begin
        #1;
        if (mem_req && ack_en) begin
            mem_ack   = (req_age == ack_delay);
            mem_rdata = (req_age == ack_delay) ? rd_val : 16'h0000;
            req_age++;
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 16'h0000;
            req_age   = 0;
        end
    end

    // Transaction model: one outstanding access, plus a one-cycle cooldown after it ends.
    logic              m_req = 0, m_we = 0, m_rvld = 0, m_err = 0, m_cool = 0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_wdata = '0, m_rdata = '0;
    int                m_wait = 0;
    logic              m_rd, m_wr;

    always @(posedge clk) begin
        m_rd = mem_to_reg | rtrn;
        m_wr = reg_to_mem;
        if (!rst_n) begin
            m_req = 0; m_we = 0; m_rvld = 0; m_err = 0; m_cool = 0;
            m_addr = '0; m_wdata = '0; m_rdata = '0; m_wait = 0;
        end else begin
            m_rvld = 0;
            m_err  = 0;
            if (m_req) begin
                if (mem_ack) begin
                    m_req  = 0;
                    m_cool = 1;
                    if (!m_we) begin
                        m_rdata = mem_rdata;
                        m_rvld  = 1;
                    end
                end else begin
                    m_wait++;
                    if (TO_EN && m_wait >= TIMEOUT) begin
                        m_req  = 0;
                        m_err  = 1;
                        m_cool = 1;
                    end
                end
            end else if (m_cool) begin
                m_cool = 0;
            end else if (valid_in) begin
                if (m_rd != m_wr) begin
                    m_req   = 1;
                    m_we    = m_wr;
                    m_addr  = addr_in;
                    m_wdata = wdata_in;
                    m_wait  = 0;
                end else if (m_rd) begin
                    m_err  = 1;
                    m_cool = 1;
                end
            end
        end
    end

    logic cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            check("mem_req", mem_req, m_req);
            check("mem_we", mem_we, m_we);
            check("mem_addr", mem_addr, m_addr);
            check("mem_wdata", mem_wdata, m_wdata);
            check("rdata_out", rdata_out, m_rdata);
            check("rdata_valid", rdata_valid, m_rvld);
            check("err", err, m_err);
            check("stall", stall, m_req | (!m_cool && valid_in &&
                                           ((mem_to_reg | rtrn) | reg_to_mem)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic m2r, input logic r2m, input logic c,
                         input logic r, input logic [15:0] a, input logic [15:0] d);
        valid_in = v; mem_to_reg = m2r; reg_to_mem = r2m; call = c; rtrn = r;
        addr_in = a; wdata_in = d;
    endtask

    // Presents an op, holds it while stalled, then returns to idle.
    task automatic run_op(input logic m2r, input logic r2m, input logic c, input logic r,
                          input logic [15:0] a, input logic [15:0] d,
                          output int req_cyc, output int rvld_cyc, output int err_cyc);
        bit done;
        req_cyc = 0; rvld_cyc = 0; err_cyc = 0; done = 0;
        drive(1, m2r, r2m, c, r, a, d);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mem_req) req_cyc++;
            if (rdata_valid) rvld_cyc++;
            if (err) err_cyc++;
            if (!stall) begin
                done = 1;
                break;
            end
            tick();
        end
        check("op_completes", done, 1);
        tick();
        drive(0, 0, 0, 0, 0, 16'h0, 16'h0);
    endtask

    int rq, rv, er;

    initial begin
        drive(0, 0, 0, 0, 0, 16'h0, 16'h0);
        rst_n = 0;
        tick();
        tick();
        @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_rdata_out", rdata_out, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_err", err, 0);
        check("rst_stall", stall, 0);
        cmp_en = 1;
        tick();
        rst_n = 1;
        tick();

        // LW with immediate ack
        ack_en = 1; ack_delay = 0; rd_val = 16'hBEEF;
        drive(1, 1, 0, 0, 0, 16'h0040, 16'h0000);
        @(negedge clk);
        check("lw_c0_stall", stall, 1);
        check("lw_c0_req", mem_req, 0);
        tick();
        @(negedge clk);
        check("lw_c1_req", mem_req, 1);
        check("lw_c1_we", mem_we, 0);
        check("lw_c1_addr", mem_addr, 16'h0040);
        check("lw_c1_stall", stall, 1);
        tick();
        @(negedge clk);
        check("lw_c2_rvld", rdata_valid, 1);
        check("lw_c2_rdata", rdata_out, 16'hBEEF);
        check("lw_c2_stall", stall, 0);
        tick();
        drive(0, 0, 0, 0, 0, 16'h0, 16'h0);
        @(negedge clk);
        check("lw_c3_rvld", rdata_valid, 0);
        tick();

        // RET (stack pop) with one-cycle ack delay
        ack_delay = 1; rd_val = 16'hCAFE;
        run_op(0, 0, 0, 1, 16'h7FFE, 16'h0000, rq, rv, er);
        check("ret_req_cycles", rq, 2);
        check("ret_rvld", rv, 1);
        check("ret_rdata", rdata_out, 16'hCAFE);

        // SW then CALL push, ack delayed 3 cycles
        ack_delay = 3;
        run_op(0, 1, 0, 0, 16'h00FE, 16'h1234, rq, rv, er);
        check("sw_req_cycles", rq, 4);
        check("sw_rvld", rv, 0);
        run_op(0, 1, 1, 0, 16'h00FE, 16'h1234, rq, rv, er);
        check("call_req_cycles", rq, 4);
        check("call_rvld", rv, 0);
        check("call_rdata_held", rdata_out, 16'hCAFE);

        // Non-memory instructions
        drive(1, 0, 0, 0, 0, 16'h1111, 16'h2222);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("nop_req", mem_req, 0);
            check("nop_stall", stall, 0);
            check("nop_err", err, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 16'h0, 16'h0);

        // Illegal load+store
        drive(1, 1, 1, 0, 0, 16'h0010, 16'h0020);
        @(negedge clk);
        check("ill_c0_stall", stall, 1);
        check("ill_c0_err", err, 0);
        tick();
        drive(0, 0, 0, 0, 0, 16'h0, 16'h0);
        @(negedge clk);
        check("ill_c1_err", err, 1);
        check("ill_c1_req", mem_req, 0);
        check("ill_c1_stall", stall, 0);
        tick();
        @(negedge clk);
        check("ill_c2_err", err, 0);
        check("ill_rdata_held", rdata_out, 16'hCAFE);
        tick();
        run_op(0, 1, 0, 1, 16'h0030, 16'h0040, rq, rv, er);
        check("ill_ret_push_err", er, 1);
        check("ill_ret_push_req", rq, 0);

        // Reset while a request is outstanding
        ack_en = 0;
        drive(1, 1, 0, 0, 0, 16'h0050, 16'h0000);
        tick();
        @(negedge clk);
        check("rst_mid_req_before", mem_req, 1);
        tick();
        rst_n = 0;
        drive(0, 0, 0, 0, 0, 16'h0, 16'h0);
        tick();
        @(negedge clk);
        check("rst_mid_req_after", mem_req, 0);
        check("rst_mid_stall", stall, 0);
        tick();
        rst_n = 1;
        ack_en = 1; ack_delay = 0; rd_val = 16'h5A5A;
        run_op(1, 0, 0, 0, 16'h0060, 16'h0000, rq, rv, er);
        check("post_rst_rvld", rv, 1);
        check("post_rst_rdata", rdata_out, 16'h5A5A);

        // Memory never acks
        ack_en = 0;
        drive(1, 1, 0, 0, 0, 16'h0070, 16'h0000);
        tick();
        drive(0, 0, 0, 0, 0, 16'h0, 16'h0);
        rq = 0; er = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (mem_req) rq++;
            if (err) er++;
            tick();
        end
        if (TO_EN) begin
            check("to_req_cycles", rq, TIMEOUT);
            check("to_err_pulses", er, 1);
        end else begin
            check("noto_req_cycles", rq, 120);
            check("noto_err_pulses", er, 0);
        end
        @(negedge clk);
        check("to_end_stall", stall, TO_EN ? 1'b0 : 1'b1);
        tick();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
